// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the machine-mode trap sequencer.
//   trap_state_e : sequencer states (idle, drain, enter, return)
//   trap_kind_e  : which source started the current trap sequence
//   IrqId*       : standard interrupt ids (MSI, MTI, MEI)
//   IrqLegalMask : every interrupt id the sequencer knows how to prioritise
// -----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StEnter,
        StReturn
    } trap_state_e;

    typedef enum logic {
        KindExc,
        KindIrq
    } trap_kind_e;

    localparam logic [4:0] IrqIdMsi = 5'd3;
    localparam logic [4:0] IrqIdMti = 5'd7;
    localparam logic [4:0] IrqIdMei = 5'd11;

    // MSI, MTI, MEI and the local interrupts 16..31.
    localparam logic [31:0] IrqLegalMask = 32'hFFFF_0888;

    // mcause value for an interrupt: interrupt flag in the MSB, id in the low bits.
    function automatic logic [31:0] irq_cause(input logic [4:0] id);
        return {1'b1, 26'b0, id};
    endfunction

    // mcause value for a synchronous exception.
    function automatic logic [31:0] exc_cause(input logic [3:0] code);
        return {28'b0, code};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Combinational fixed-priority encoder for pending interrupts.
// Priority: MEI (11) > MSI (3) > MTI (7) > local 16..31 (lowest id first).
// Bits outside the legal id set are ignored.
//   pending in  32 : masked pending vector (ip & ie & mask)
//   valid   out 1  : at least one legal id is pending
//   id      out 5  : winning interrupt id (0 when valid is low)
// -----------------------------------------------------------------------------
module irq_prio_enc
    import core_pkg::*;
(
    input  logic [31:0] pending,
    output logic        valid,
    output logic [4:0]  id
);

    always_comb begin
        valid = 1'b1;
        id    = '0;
        if (pending[IrqIdMei]) begin
            id = IrqIdMei;
        end else if (pending[IrqIdMsi]) begin
            id = IrqIdMsi;
        end else if (pending[IrqIdMti]) begin
            id = IrqIdMti;
        end else begin
            valid = 1'b0;
            // Walk downwards so the lowest pending local id is the last one written.
            for (int i = 31; i >= 16; i--) begin
                if (pending[i]) begin
                    valid = 1'b1;
                    id    = 5'(i);
                end
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Machine-mode trap sequencer. Picks one trap source per event (exception >
// interrupt > mret), stalls fetch while the pipeline drains, then emits a
// single-cycle trap-entry or return pulse to the CSR unit plus a PC redirect.
//
// Build option: define TRAP_VECTORED_EN to enable vectored interrupt entry
// (mtvec mode 2'b01 -> base + 4*id for interrupts). Without it every trap goes
// to the mtvec base and mtvec[1:0] is ignored.
//
// Ports:
//   clk_i, reset_ni    : clock, asynchronous active-low reset
//   ip_i, ie_i         : MIP / MIE from the CSR unit
//   status_i           : MSTATUS (bit 3 = MIE)
//   vec_i, mepc_i      : MTVEC / MEPC from the CSR unit
//   exc_valid_i        : synchronous exception from the pipeline
//   exc_cause_i        : exception code
//   exc_pc_i           : PC of the faulting instruction
//   mret_i             : mret decoded
//   pipe_idle_i        : all older instructions retired
//   next_pc_i          : PC of the oldest unexecuted instruction
//   stall_o            : hold fetch/issue (decoded from state only)
//   trap_valid_o       : trap-entry strobe to the CSR unit
//   ecause_o, epc_o    : cause and PC to record on trap entry
//   ret_o              : mret strobe to the CSR unit
//   redirect_o         : PC redirect strobe
//   redirect_pc_o      : redirect target
// -----------------------------------------------------------------------------
module trap_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] IRQ_MASK = 32'hFFFF_0888
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] ip_i,
    input  logic [31:0] ie_i,
    input  logic [31:0] status_i,
    input  logic [31:0] vec_i,
    input  logic [31:0] mepc_i,
    input  logic        exc_valid_i,
    input  logic [3:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic        mret_i,
    input  logic        pipe_idle_i,
    input  logic [31:0] next_pc_i,
    output logic        stall_o,
    output logic        trap_valid_o,
    output logic [31:0] ecause_o,
    output logic [31:0] epc_o,
    output logic        ret_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    trap_state_e state_q, state_d;
    trap_kind_e  kind_q, kind_d;
    logic [3:0]  exc_code_q, exc_code_d;
    logic [31:0] exc_pc_q, exc_pc_d;

    logic        trap_valid_d;
    logic        ret_d;
    logic        redirect_d;
    logic [31:0] ecause_d;
    logic [31:0] epc_d;
    logic [31:0] redirect_pc_d;

    logic [31:0] pending;
    logic        irq_valid;
    logic [4:0]  irq_id;
    logic        irq_pending;
    logic [31:0] vec_base;
    logic [31:0] irq_target;

    // Only status bit 3 and the mtvec base/mode bits are consumed here.
    logic unused_inputs;
    assign unused_inputs = ^{status_i[31:4], status_i[2:0], vec_i[1:0]};

    // Ids outside the legal set cannot be prioritised, so drop them up front to
    // keep "pending" and "encoder valid" equivalent.
    assign pending     = ip_i & ie_i & IRQ_MASK & IrqLegalMask;
    assign irq_pending = status_i[3] & irq_valid;

    // Shared between the IDLE detect and the DRAIN re-evaluation.
    irq_prio_enc u_irq_prio_enc (
        .pending (pending),
        .valid   (irq_valid),
        .id      (irq_id)
    );

    assign vec_base = {vec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign irq_target = (vec_i[1:0] == 2'b01) ? vec_base + {25'b0, irq_id, 2'b00} : vec_base;
`else
    assign irq_target = vec_base;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            kind_q     <= KindExc;
            exc_code_q <= '0;
            exc_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            exc_code_q <= exc_code_d;
            exc_pc_q   <= exc_pc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        exc_code_d = exc_code_q;
        exc_pc_d   = exc_pc_q;
        unique case (state_q)
            StIdle: begin
                if (exc_valid_i) begin
                    kind_d     = KindExc;
                    exc_code_d = exc_cause_i;
                    exc_pc_d   = exc_pc_i;
                    state_d    = StDrain;
                end else if (irq_pending) begin
                    kind_d  = KindIrq;
                    state_d = StDrain;
                end else if (mret_i) begin
                    state_d = StReturn;
                end
            end
            StDrain: begin
                if (pipe_idle_i) begin
                    if (kind_q == KindExc || irq_pending) begin
                        state_d = StEnter;
                    end else begin
                        // Interrupt withdrawn while draining: abandon silently.
                        state_d = StIdle;
                    end
                end
            end
            StEnter:  state_d = StIdle;
            StReturn: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: next values of the registered strobes, loaded on the edge
    // that enters ENTER or RETURN so they are high for exactly that cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        trap_valid_d  = 1'b0;
        ret_d         = 1'b0;
        redirect_d    = 1'b0;
        ecause_d      = '0;
        epc_d         = '0;
        redirect_pc_d = '0;
        if (state_q == StDrain && state_d == StEnter) begin
            trap_valid_d = 1'b1;
            redirect_d   = 1'b1;
            if (kind_q == KindExc) begin
                ecause_d      = exc_cause(exc_code_q);
                epc_d         = exc_pc_q;
                redirect_pc_d = vec_base;
            end else begin
                // Winner re-evaluated now; it may differ from the id seen in IDLE.
                ecause_d      = irq_cause(irq_id);
                epc_d         = next_pc_i;
                redirect_pc_d = irq_target;
            end
        end else if (state_q == StIdle && state_d == StReturn) begin
            ret_d         = 1'b1;
            redirect_d    = 1'b1;
            redirect_pc_d = mepc_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            trap_valid_o  <= 1'b0;
            ret_o         <= 1'b0;
            redirect_o    <= 1'b0;
            ecause_o      <= '0;
            epc_o         <= '0;
            redirect_pc_o <= '0;
        end else begin
            trap_valid_o  <= trap_valid_d;
            ret_o         <= ret_d;
            redirect_o    <= redirect_d;
            ecause_o      <= ecause_d;
            epc_o         <= epc_d;
            redirect_pc_o <= redirect_pc_d;
        end
    end

    assign stall_o = (state_q != StIdle);

endmodule

// File: tb/tb_trap_ctrl.sv
`timescale 1ns/1ps
// Directed bench for trap_ctrl. Inputs change and outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge.
module tb_trap_ctrl;

`ifdef TRAP_VECTORED_EN
    localparam bit Vect = 1'b1;
`else
    localparam bit Vect = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [31:0] ip_i, ie_i, status_i, vec_i, mepc_i, exc_pc_i, next_pc_i;
    logic        exc_valid_i, mret_i, pipe_idle_i;
    logic [3:0]  exc_cause_i;
    logic        stall_o, trap_valid_o, ret_o, redirect_o;
    logic [31:0] ecause_o, epc_o, redirect_pc_o;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    trap_ctrl dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .ip_i          (ip_i),
        .ie_i          (ie_i),
        .status_i      (status_i),
        .vec_i         (vec_i),
        .mepc_i        (mepc_i),
        .exc_valid_i   (exc_valid_i),
        .exc_cause_i   (exc_cause_i),
        .exc_pc_i      (exc_pc_i),
        .mret_i        (mret_i),
        .pipe_idle_i   (pipe_idle_i),
        .next_pc_i     (next_pc_i),
        .stall_o       (stall_o),
        .trap_valid_o  (trap_valid_o),
        .ecause_o      (ecause_o),
        .epc_o         (epc_o),
        .ret_o         (ret_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o)
    );

    typedef struct {
        string       name;
        logic [31:0] ip, ie, status, vec, mepc, next_pc;
        logic        exc_valid;
        logic [3:0]  exc_cause;
        logic [31:0] exc_pc;
        logic        mret;
        int          drain;   // DRAIN cycles; pipe_idle is high in the last one
        logic        is_ret;
        logic [31:0] ecause, epc, rpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [31:0] ip, ie, status, vec,
                                mepc, next_pc, input logic exc_valid, input logic [3:0] exc_cause,
                                input logic [31:0] exc_pc, input logic mret, input int drain,
                                input logic is_ret, input logic [31:0] ecause, epc, rpc);
        vec_t v;
        v.name = name; v.ip = ip; v.ie = ie; v.status = status; v.vec = vec; v.mepc = mepc;
        v.next_pc = next_pc; v.exc_valid = exc_valid; v.exc_cause = exc_cause;
        v.exc_pc = exc_pc; v.mret = mret; v.drain = drain; v.is_ret = is_ret;
        v.ecause = ecause; v.epc = epc; v.rpc = rpc;
        return v;
    endfunction

    // {stall, trap_valid, ret, redirect, ecause, epc, redirect_pc}
    function automatic logic [99:0] ex(input logic st, tv, rt, rd, input logic [31:0] c, e, p);
        return {st, tv, rt, rd, c, e, p};
    endfunction

    task automatic check(input string name, input logic [99:0] exp);
        logic [99:0] act;
        act = {stall_o, trap_valid_o, ret_o, redirect_o, ecause_o, epc_o, redirect_pc_o};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got stall=%b trap=%b ret=%b redir=%b cause=%h epc=%h pc=%h ; want stall=%b trap=%b ret=%b redir=%b cause=%h epc=%h pc=%h",
                     name, act[99], act[98], act[97], act[96], act[95:64], act[63:32], act[31:0],
                     exp[99], exp[98], exp[97], exp[96], exp[95:64], exp[63:32], exp[31:0]);
        end
    endtask

    task automatic quiet_inputs();
        ip_i = '0; ie_i = '0; status_i = '0; vec_i = '0; mepc_i = '0; exc_pc_i = '0;
        next_pc_i = '0; exc_valid_i = 1'b0; mret_i = 1'b0; pipe_idle_i = 1'b0;
        exc_cause_i = '0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk_i);
        check({v.name, "/pre"}, ex(0, 0, 0, 0, 0, 0, 0));
        ip_i = v.ip; ie_i = v.ie; status_i = v.status; vec_i = v.vec; mepc_i = v.mepc;
        next_pc_i = v.next_pc; exc_valid_i = v.exc_valid; exc_cause_i = v.exc_cause;
        exc_pc_i = v.exc_pc; mret_i = v.mret; pipe_idle_i = 1'b0;
        if (v.is_ret) begin
            @(negedge clk_i);
            check({v.name, "/ret"}, ex(1, 0, 1, 1, 0, 0, v.rpc));
            quiet_inputs();
        end else begin
            for (int j = 1; j <= v.drain; j++) begin
                @(negedge clk_i);
                check({v.name, "/drain"}, ex(1, 0, 0, 0, 0, 0, 0));
                // Scramble the exception inputs: the latched copies must be used.
                exc_valid_i = 1'b0; mret_i = 1'b0; exc_cause_i = 4'h9; exc_pc_i = 32'hBAD0_0000;
                pipe_idle_i = (j == v.drain);
            end
            @(negedge clk_i);
            check({v.name, "/enter"}, ex(1, 1, 0, 1, v.ecause, v.epc, v.rpc));
            quiet_inputs();
        end
        @(negedge clk_i);
        check({v.name, "/post"}, ex(0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        reset_ni = 1'b0;
        quiet_inputs();

        // ---- Reset with random inputs, then release quietly ----
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("reset_hold", ex(0, 0, 0, 0, 0, 0, 0));
            ip_i = $urandom; ie_i = $urandom; status_i = $urandom; vec_i = $urandom;
            mepc_i = $urandom; exc_pc_i = $urandom; next_pc_i = $urandom;
            exc_valid_i = 1'($urandom); mret_i = 1'($urandom); pipe_idle_i = 1'($urandom);
            exc_cause_i = 4'($urandom);
        end
        @(negedge clk_i);
        quiet_inputs();
        reset_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("reset_release", ex(0, 0, 0, 0, 0, 0, 0));
        end

        // ---- Table-driven scenarios ----
        vecs.push_back(mk("mei_direct", 32'h800, 32'h800, 32'h8, 32'h100, 0, 32'h2000,
                          0, 0, 0, 0, 3, 0, 32'h8000_000B, 32'h2000, 32'h100));
        vecs.push_back(mk("mei_vectored", 32'h888, 32'h888, 32'h8, 32'h101, 0, 32'h3000,
                          0, 0, 0, 0, 1, 0, 32'h8000_000B, 32'h3000, Vect ? 32'h12C : 32'h100));
        vecs.push_back(mk("msi_over_mti_mode3", 32'h88, 32'h88, 32'h8, 32'h103, 0, 32'h44,
                          0, 0, 0, 0, 2, 0, 32'h8000_0003, 32'h44, 32'h100));
        vecs.push_back(mk("local_lowest", 32'h000A_0080, 32'h000A_0000, 32'h8, 32'h201, 0,
                          32'h1234, 0, 0, 0, 0, 1, 0, 32'h8000_0011, 32'h1234,
                          Vect ? 32'h244 : 32'h200));
        vecs.push_back(mk("mti_base0", 32'h80, 32'h80, 32'h88, 32'h1, 0, 32'h8,
                          0, 0, 0, 0, 1, 0, 32'h8000_0007, 32'h8, Vect ? 32'h1C : 32'h0));
        vecs.push_back(mk("exc_beats_irq", 32'h80, 32'h80, 32'h8, 32'h101, 0, 32'h5000,
                          1, 4'h2, 32'h40, 0, 2, 0, 32'h2, 32'h40, 32'h100));
        vecs.push_back(mk("exc_max_cause", 0, 0, 0, 32'h8000_0002, 0, 0,
                          1, 4'hF, 32'hDEAD_BEE0, 0, 1, 0, 32'hF, 32'hDEAD_BEE0, 32'h8000_0000));
        vecs.push_back(mk("mret_plain", 0, 0, 0, 0, 32'h2000, 0,
                          0, 0, 0, 1, 0, 1, 0, 0, 32'h2000));
        vecs.push_back(mk("irq_beats_mret", 32'h800, 32'h800, 32'h8, 32'h100, 32'h2000, 32'h600,
                          0, 0, 0, 1, 1, 0, 32'h8000_000B, 32'h600, 32'h100));
        vecs.push_back(mk("mret_bit0_masked", 32'h1, 32'h1, 32'h8, 0, 32'h4444, 0,
                          0, 0, 0, 1, 0, 1, 0, 0, 32'h4444));
        vecs.push_back(mk("mret_mie_off", 32'h800, 32'h800, 32'h0, 0, 32'h8888, 0,
                          0, 0, 0, 1, 0, 1, 0, 0, 32'h8888));
        vecs.push_back(mk("exc_beats_mret", 0, 0, 0, 0, 32'h9999, 0,
                          1, 4'h7, 32'h100, 1, 1, 0, 32'h7, 32'h100, 32'h0));
        foreach (vecs[k]) run_vec(vecs[k]);

        // ---- Abandon: interrupt withdrawn during DRAIN ----
        @(negedge clk_i);
        ip_i = 32'h800; ie_i = 32'h800; status_i = 32'h8; vec_i = 32'h100;
        @(negedge clk_i);
        check("abandon/drain1", ex(1, 0, 0, 0, 0, 0, 0));
        ip_i = '0;
        @(negedge clk_i);
        check("abandon/drain2", ex(1, 0, 0, 0, 0, 0, 0));
        pipe_idle_i = 1'b1;
        @(negedge clk_i);
        check("abandon/idle", ex(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk_i);
        check("abandon/stay", ex(0, 0, 0, 0, 0, 0, 0));
        quiet_inputs();

        // ---- Priority re-evaluated at drain exit; exception ignored in DRAIN ----
        @(negedge clk_i);
        ip_i = 32'h80; ie_i = 32'h880; status_i = 32'h8; vec_i = 32'h100; next_pc_i = 32'h700;
        @(negedge clk_i);
        check("reeval/drain", ex(1, 0, 0, 0, 0, 0, 0));
        ip_i = 32'h880; pipe_idle_i = 1'b1;
        exc_valid_i = 1'b1; exc_cause_i = 4'h5; exc_pc_i = 32'h55;
        @(negedge clk_i);
        check("reeval/enter", ex(1, 1, 0, 1, 32'h8000_000B, 32'h700, 32'h100));
        quiet_inputs();
        @(negedge clk_i);
        check("reeval/post", ex(0, 0, 0, 0, 0, 0, 0));

        // ---- Reset asserted mid-DRAIN ----
        @(negedge clk_i);
        ip_i = 32'h800; ie_i = 32'h800; status_i = 32'h8;
        @(negedge clk_i);
        check("rst_drain/drain", ex(1, 0, 0, 0, 0, 0, 0));
        reset_ni = 1'b0;
        #1;
        check("rst_drain/async", ex(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk_i);
        quiet_inputs();
        reset_ni = 1'b1;
        @(negedge clk_i);
        check("rst_drain/after", ex(0, 0, 0, 0, 0, 0, 0));

        // ---- Reset asserted during the ENTER pulse ----
        ip_i = 32'h800; ie_i = 32'h800; status_i = 32'h8; vec_i = 32'h100;
        next_pc_i = 32'h900; pipe_idle_i = 1'b1;
        @(negedge clk_i);
        check("rst_pulse/drain", ex(1, 0, 0, 0, 0, 0, 0));
        @(negedge clk_i);
        check("rst_pulse/enter", ex(1, 1, 0, 1, 32'h8000_000B, 32'h900, 32'h100));
        quiet_inputs();
        reset_ni = 1'b0;
        #1;
        check("rst_pulse/async", ex(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        check("rst_pulse/after", ex(0, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
